// File: rtl/display_pkg.sv
// Shared definitions for the segment-display front panel: status encoding,
// button indices and small helpers used by display_speed_ctrl.
package display_pkg;

  // Status code consumed by the segment-display datapath.
  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_MID   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_PAUSE = 2'd3
  } status_t;

  // Controller state; the encoding is identical to status_t so it drives status directly.
  typedef enum logic [1:0] {
    S_LOW   = 2'd0,
    S_MID   = 2'd1,
    S_HIGH  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  localparam int NUM_BTN   = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_PAUSE = 2;
  localparam int BTN_STEP  = 3;

  localparam logic [1:0] SPD_MAX = 2'd2;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return clk_freq / 1000 * ms;
  endfunction

  function automatic logic [1:0] spd_up(input logic [1:0] spd);
    return (spd >= SPD_MAX) ? SPD_MAX : spd + 2'd1;
  endfunction

  function automatic logic [1:0] spd_down(input logic [1:0] spd);
    return (spd == 2'd0) ? 2'd0 : spd - 2'd1;
  endfunction

  function automatic logic [3:0] to_led(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  // The accepted level flips on the edge where the synced level has
  // differed for DB_CYCLES consecutive samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/display_speed_ctrl.sv
// Front-panel speed/pause controller for the segment display.
// Optional step auto-repeat in PAUSE: define DISPLAY_SPEED_CTRL_REPEAT_EN.
module display_speed_ctrl
  import display_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned REPEAT_MS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_pause,
  input  logic       btn_step,
  output logic [1:0] status,
  output logic       step_pulse,
  output logic [3:0] mode_led
);

  localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;

  assign btn_raw[BTN_UP]    = btn_up;
  assign btn_raw[BTN_DOWN]  = btn_down;
  assign btn_raw[BTN_PAUSE] = btn_pause;
  assign btn_raw[BTN_STEP]  = btn_step;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn_raw[gi]),
        .level(btn_level[gi]),
        .press(btn_press[gi])
      );
    end
  endgenerate

  state_t     state_reg, state_next;
  logic [1:0] saved_reg, saved_next;
  logic       step_reg, step_next;
  logic [3:0] led_reg, led_next;
  logic       rpt_fire;

`ifdef DISPLAY_SPEED_CTRL_REPEAT_EN
  localparam int unsigned RPT_CYCLES = ms_to_cycles(CLK_FREQ, REPEAT_MS);
  localparam int RW = (RPT_CYCLES > 1) ? $clog2(RPT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(RPT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt_reg, rpt_cnt_next;

  // Counts only while paused with step held; the press itself restarts it.
  always_comb begin
    rpt_fire     = 1'b0;
    rpt_cnt_next = '0;
    if (state_reg == S_PAUSE && btn_level[BTN_STEP] && !btn_press[BTN_STEP]) begin
      if (rpt_cnt_reg == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_cnt_next = rpt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_reg <= '0;
    end else begin
      rpt_cnt_reg <= rpt_cnt_next;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, btn_level, REPEAT_MS[0]};

  // One winner per cycle: pause > up > down > step.
  always_comb begin
    state_next = state_reg;
    saved_next = saved_reg;
    step_next  = 1'b0;
    if (btn_press[BTN_PAUSE]) begin
      if (state_reg == S_PAUSE) begin
        state_next = state_t'(saved_reg);
      end else begin
        saved_next = state_reg;
        state_next = S_PAUSE;
      end
    end else if (btn_press[BTN_UP]) begin
      if (state_reg == S_PAUSE) begin
        saved_next = spd_up(saved_reg);
      end else begin
        state_next = state_t'(spd_up(state_reg));
      end
    end else if (btn_press[BTN_DOWN]) begin
      if (state_reg == S_PAUSE) begin
        saved_next = spd_down(saved_reg);
      end else begin
        state_next = state_t'(spd_down(state_reg));
      end
    end else if (btn_press[BTN_STEP]) begin
      step_next = (state_reg == S_PAUSE);
    end
    if (rpt_fire && !btn_press[BTN_PAUSE]) begin
      step_next = 1'b1;
    end
    led_next = to_led(state_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_LOW;
      saved_reg <= 2'd0;
      step_reg  <= 1'b0;
      led_reg   <= 4'b0001;
    end else begin
      state_reg <= state_next;
      saved_reg <= saved_next;
      step_reg  <= step_next;
      led_reg   <= led_next;
    end
  end

  assign status     = state_reg;
  assign step_pulse = step_reg;
  assign mode_led   = led_reg;

endmodule

// File: tb/tb_display_speed_ctrl.sv
// Scoreboard bench for display_speed_ctrl: button presses are scored by a
// speed/pause reference model and a monitor matches every visible output event.
module tb_display_speed_ctrl;

  localparam int DB  = 4;
  localparam int RPT = 5;
`ifdef DISPLAY_SPEED_CTRL_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_pause = 1'b0, btn_step = 1'b0;
  logic [1:0] status;
  logic       step_pulse;
  logic [3:0] mode_led;

  always #5 clk = ~clk;

  display_speed_ctrl #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(4),
    .REPEAT_MS  (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_pause (btn_pause),
    .btn_step  (btn_step),
    .status    (status),
    .step_pulse(step_pulse),
    .mode_led  (mode_led)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    bit is_step;
    int st;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  mdl_st = 0;
  int  mdl_saved = 0;

  function automatic void check(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  function automatic void push_ev(int at, bit is_step, int st);
    ev_t e;
    e.at = at;
    e.is_step = is_step;
    e.st = st;
    exp_q.push_back(e);
  endfunction

  // Reference model: what one accepted press set does to speed/pause.
  function automatic void model_apply(logic [3:0] mask, int c0, int hold);
    int at = c0 + 3 + DB;
    int nxt;
    if (mask[2]) begin
      if (mdl_st == 3) mdl_st = mdl_saved;
      else begin
        mdl_saved = mdl_st;
        mdl_st = 3;
      end
      push_ev(at, 1'b0, mdl_st);
    end else if (mask[0] || mask[1]) begin
      if (mdl_st == 3) begin
        mdl_saved = mask[0] ? ((mdl_saved < 2) ? mdl_saved + 1 : 2)
                            : ((mdl_saved > 0) ? mdl_saved - 1 : 0);
      end else begin
        nxt = mask[0] ? ((mdl_st < 2) ? mdl_st + 1 : 2)
                      : ((mdl_st > 0) ? mdl_st - 1 : 0);
        if (nxt != mdl_st) push_ev(at, 1'b0, nxt);
        mdl_st = nxt;
      end
    end else if (mask[3] && mdl_st == 3) begin
      push_ev(at, 1'b1, 3);
      if (RPT_EN) begin
        for (int k = 1; k * RPT <= hold - 1; k++) push_ev(at + k * RPT, 1'b1, 3);
      end
    end
  endfunction

  function automatic void observe(bit is_step, int st);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got %s=%0d at cycle %0d, expected none",
               is_step ? "step" : "status", st, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.is_step != is_step || e.st != st || e.at != cyc) begin
      n_err++;
      $display("FAIL event: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
               is_step ? "step" : "status", st, cyc,
               e.is_step ? "step" : "status", e.st, e.at);
    end
    if (!is_step) check("mode_led", int'(mode_led), 1 << e.st);
  endfunction

  // Monitor: every status change and every step pulse is an event.
  int prev_st = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_st <= 0;
    end else begin
      if (int'(status) != prev_st) observe(1'b0, int'(status));
      if (step_pulse) observe(1'b1, 3);
      prev_st <= int'(status);
    end
  end

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    int c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    {btn_step, btn_pause, btn_down, btn_up} = mask;
    if (hold >= DB) model_apply(mask, c0, hold);
    repeat (hold) @(posedge clk);
    #1;
    {btn_step, btn_pause, btn_down, btn_up} = 4'b0000;
    repeat (gap) @(posedge clk);
  endtask

  // mask bits: 0 up, 1 down, 2 pause, 3 step
  localparam int N_DIR = 23;
  int dir_mask [N_DIR] = '{1, 1, 1, 1, 2, 2, 2, 1, 1, 1, 4, 2, 4, 4, 8, 4, 8, 2, 5, 4, 4, 8, 4};
  int dir_hold [N_DIR] = '{10, 5, 5, 5, 5, 5, 5, 3, 4, 4, 5, 5, 4, 4, 5, 4, 5, 4, 4, 4, 4, 20, 4};

  initial begin
    int c0;
    logic [3:0] m;
    int h;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_status", int'(status), 0);
    check("reset_mode_led", int'(mode_led), 1);
    check("reset_step_pulse", int'(step_pulse), 0);
    rst_n = 1'b1;

    for (int i = 0; i < N_DIR; i++) press(4'(dir_mask[i]), dir_hold[i], DB + 4);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 8) m = 4'b0001 << $urandom_range(0, 3);
      else m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 5) == 0) h = $urandom_range(1, DB - 1);
      else if (m[3] && m != 4'b1000) h = $urandom_range(DB, DB + 1);
      else h = $urandom_range(DB, DB + 16);
      press(m, h, $urandom_range(DB + 2, DB + 8));
    end

    // Reset while paused with step held, then hold up across reset release.
    if (mdl_st != 3) press(4'b0100, DB, DB + 4);
    @(posedge clk);
    #1;
    c0 = cyc;
    btn_step = 1'b1;
    push_ev(c0 + 3 + DB, 1'b1, 3);
    repeat (DB + 5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    btn_step = 1'b0;
    btn_up = 1'b1;
    #1;
    check("midrst_status", int'(status), 0);
    check("midrst_mode_led", int'(mode_led), 1);
    check("midrst_step_pulse", int'(step_pulse), 0);
    mdl_st = 0;
    mdl_saved = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    c0 = cyc;
    mdl_st = 1;
    push_ev(c0 + 3 + DB, 1'b0, 1);
    repeat (10) @(posedge clk);
    #1;
    btn_up = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
